// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master slice. It holds the bus widths, the
// wait-counter width, the default timeout and the master FSM state encoding.
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  // The wait counter must be able to hold the largest legal TIMEOUT (255).
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_if.sv
// -----------------------------------------------------------------------------
// apb_if
// Bundles the upstream command/response signals and the APB bus signals of
// one master.
//   master modport : driven by apb_master
//   slave  modport : the command source and the APB slave (the environment)
//
// Handshake rules:
//   - A command transfers on a rising edge where cmd_valid && cmd_ready. The
//     command fields must be stable while cmd_valid is high.
//   - rsp_valid is a single-cycle pulse with no backpressure. rsp_err = 1
//     marks a timeout abort. rsp_rdata is the read data, and it is 0 for
//     writes and aborts.
//   - APB: psel without pen is SETUP, psel with pen is ACCESS. pready is
//     sampled only in ACCESS.
// -----------------------------------------------------------------------------
interface apb_if;
  import apb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              pen;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, pen, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, pen, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating counter of ACCESS cycles spent waiting for pready.
//   pclk, prst : clock, asynchronous active-high reset
//   i_clear    : zero the count (has priority over i_enable)
//   i_enable   : count this cycle
//   o_expired  : the current waited cycle is the one that brings the count
//                to TIMEOUT
// -----------------------------------------------------------------------------
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic pclk,
  input  logic prst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count already holds TIMEOUT-1 waited cycles. One more cycle without
  // pready therefore reaches TIMEOUT, and the transfer aborts on that edge.
  assign o_expired = (r_count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Single-outstanding APB master. It accepts one command, runs SETUP then
// ACCESS until pready or timeout, and then emits a one-cycle response.
// All outputs are registered.
//   pclk, prst  : clock, asynchronous active-high reset
//   bus         : apb_if.master (command, response, APB signals)
//   o_dbg_state : current FSM state
// -----------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic   pclk,
  input  logic   prst,
  apb_if.master  bus,
  output state_t o_dbg_state
);

  state_t            r_state, w_state;
  logic              r_cmd_ready, w_cmd_ready;
  logic              r_psel, w_psel;
  logic              r_pen, w_pen;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic              r_rsp_err, w_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              w_accept;
  logic              w_timer_clear;
  logic              w_timer_en;
  logic              w_expired;

  assign w_accept = bus.cmd_valid && r_cmd_ready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .pclk      (pclk),
    .prst      (prst),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_pen       <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_psel      <= w_psel;
      r_pen       <= w_pen;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_psel        = r_psel;
    w_pen         = r_pen;
    w_pwrite      = r_pwrite;
    w_paddr       = r_paddr;
    w_pwdata      = r_pwdata;
    w_rsp_valid   = 1'b0;
    w_rsp_err     = 1'b0;
    w_rsp_rdata   = '0;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state  = ST_SETUP;
          w_psel   = 1'b1;
          w_pen    = 1'b0;
          w_pwrite = bus.cmd_write;
          w_paddr  = bus.cmd_addr;
          // Reads drive a clean zero on pwdata instead of stale upstream data.
          w_pwdata = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end
      ST_SETUP: begin
        w_state       = ST_ACCESS;
        w_pen         = 1'b1;
        w_timer_clear = 1'b1;
      end
      ST_ACCESS: begin
        w_timer_en = !bus.pready;
        // A completion wins over a timeout that expires on the same cycle.
        if (bus.pready) begin
          w_state     = ST_IDLE;
          w_psel      = 1'b0;
          w_pen       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : bus.prdata;
        end else if (w_expired) begin
          w_state     = ST_IDLE;
          w_psel      = 1'b0;
          w_pen       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_psel  = 1'b0;
        w_pen   = 1'b0;
      end
    endcase
  end

  // The master is ready exactly when it is, or is about to be, in IDLE. This
  // lets a new command be accepted on the same cycle as the response pulse.
  assign w_cmd_ready = (w_state == ST_IDLE);

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.psel      = r_psel;
  assign bus.pen       = r_pen;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Bench for apb_master with TIMEOUT=4. A memory-backed APB slave stalls each
// transfer by a chosen number of wait cycles. The expected response of each
// command is computed from a reference memory when the command is issued.
// -----------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int EXP_W      = 34;

  logic   pclk;
  logic   prst;
  state_t dbg_state;

  apb_if bus();

  apb_master #(.TIMEOUT(TB_TIMEOUT)) dut (
    .pclk        (pclk),
    .prst        (prst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- shared state ----------------
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [7:0]        mem     [256];
  logic [7:0]        ref_mem [256];
  logic [EXP_W-1:0]  exp_q   [$];
  int                wait_q  [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Packed fields: {addr, wdata, write, pen_cycles, err, rdata}.
  function automatic logic [EXP_W-1:0] pack(input logic [7:0] a, input logic [7:0] d,
                                            input logic wr, input logic [7:0] len,
                                            input logic err, input logic [7:0] rd);
    return {a, d, wr, len, err, rd};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int w, input bit expect_rsp, output bit rdy_on_rsp);
    bit         to;
    int         len;
    int         n;
    logic [7:0] exp_d;
    logic [7:0] exp_rd;
    to     = (w >= TB_TIMEOUT);
    len    = to ? TB_TIMEOUT : w + 1;
    exp_d  = wr ? d : 8'h00;
    exp_rd = (wr || to) ? 8'h00 : ref_mem[a];
    if (wr && !to) ref_mem[a] = d;
    if (expect_rsp) exp_q.push_back(pack(a, exp_d, wr, 8'(len), to, exp_rd));
    wait_q.push_back(w);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    rdy_on_rsp    = 1'b0;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!bus.cmd_ready && n < 100);
    if (!bus.cmd_ready) begin
      check("accept_timeout", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      rdy_on_rsp = bus.rsp_valid;
      @(posedge pclk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = 8'($urandom);
    end
  endtask

  // ---------------- APB slave model ----------------
  int cur_w;
  int acc;
  initial begin
    bus.pready = 1'b0;
    bus.prdata = 8'h00;
    cur_w = 0;
    acc   = 0;
    forever begin
      @(negedge pclk);
      if (prst) begin
        bus.pready = 1'b0;
      end else if (bus.psel && !bus.pen) begin
        if (wait_q.size() == 0) begin
          check("slave_unexpected_setup", 64'd1, 64'd0);
          cur_w = 0;
        end else begin
          cur_w = wait_q.pop_front();
        end
        acc = 0;
        // Noise on pready during SETUP must be ignored by the master.
        bus.pready = 1'($urandom_range(0, 1));
        bus.prdata = 8'($urandom);
      end else if (bus.psel && bus.pen) begin
        if (acc == cur_w) begin
          bus.pready = 1'b1;
          if (bus.pwrite) mem[bus.paddr] = bus.pwdata;
          else            bus.prdata = mem[bus.paddr];
        end else begin
          bus.pready = 1'b0;
          bus.prdata = 8'($urandom);
        end
        acc++;
      end else begin
        bus.pready = 1'($urandom_range(0, 1));
        bus.prdata = 8'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         pen_cnt;
  int         setup_cnt;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       cap_wr;
  initial begin
    pen_cnt   = 0;
    setup_cnt = 0;
    cap_addr  = '0;
    cap_wdata = '0;
    cap_wr    = 1'b0;
    forever begin
      @(negedge pclk);
      if (prst) begin
        pen_cnt   = 0;
        setup_cnt = 0;
      end else begin
        if (bus.pen && !bus.psel) check("pen_without_psel", 64'd1, 64'd0);
        if (bus.psel && !bus.pen) begin
          setup_cnt++;
          cap_addr  = bus.paddr;
          cap_wdata = bus.pwdata;
          cap_wr    = bus.pwrite;
        end
        if (bus.psel && bus.pen) begin
          pen_cnt++;
          check("access_stable", {bus.paddr, bus.pwdata, bus.pwrite},
                {cap_addr, cap_wdata, cap_wr});
        end
        if (bus.rsp_valid) begin
          check("rsp_psel_low", 64'({bus.psel, bus.pen}), 64'd0);
          check("setup_cycles", 64'(setup_cnt), 64'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            check("rsp", 64'(pack(cap_addr, cap_wdata, cap_wr, 8'(pen_cnt),
                                  bus.rsp_err, bus.rsp_rdata)),
                  64'(exp_q.pop_front()));
          end
          pen_cnt   = 0;
          setup_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit r;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h34]     = 8'h5C;
    ref_mem[8'h34] = 8'h5C;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    prst = 1'b0;
    #2 prst = 1'b1;
    #1;
    check("reset_outputs",
          64'({bus.psel, bus.pen, bus.pwrite, bus.paddr, bus.pwdata,
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.cmd_ready}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    #1 check("ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge pclk);
    #1 check("ready_after_edge", 64'(bus.cmd_ready), 64'd1);

    // Directed cases.
    issue(1'b1, 8'h12, 8'hA5, 0, 1'b1, r);                  // write, zero waits
    issue(1'b0, 8'h34, 8'h00, 3, 1'b1, r);                  // read, 3 waits
    repeat (2) @(posedge pclk);
    issue(1'b0, 8'h56, 8'h00, 20, 1'b1, r);                 // read timeout
    issue(1'b0, 8'h12, 8'h00, TB_TIMEOUT - 1, 1'b1, r);     // ready on last cycle
    issue(1'b1, 8'h01, 8'h77, 0, 1'b1, r);                  // back-to-back pair
    issue(1'b0, 8'h02, 8'h00, 0, 1'b1, r);
    check("b2b_accept_on_rsp", 64'(r), 64'd1);
    issue(1'b0, 8'h01, 8'h00, 1, 1'b1, r);

    // Reset during ACCESS: no response may appear.
    issue(1'b0, 8'h20, 8'h00, 3, 1'b0, r);
    n = 0;
    while (!bus.pen && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("reached_access", 64'(bus.pen), 64'd1);
    #2 prst = 1'b1;
    #1 check("midreset_outputs", 64'({bus.psel, bus.pen, bus.rsp_valid, bus.cmd_ready}), 64'd0);
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    @(posedge pclk);
    #1 check("ready_after_midreset", 64'(bus.cmd_ready), 64'd1);
    issue(1'b0, 8'h34, 8'h00, 0, 1'b1, r);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 6), 1'b1, r);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge pclk);
      n++;
    end
    repeat (3) @(posedge pclk);
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);
    check("drain_wait_q", 64'(wait_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, max ACCESS cycles with pready low before abort (range 1..255).
REQ-002 pclk  in  1  single clock; all state updates on rising edge.
REQ-003 prst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  upstream command present.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  8  transfer address.
REQ-008 cmd_wdata  in  8  write data, ignored for reads.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  8  read data; 0 for writes and aborts.
REQ-011 rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
REQ-012 psel, pen, pwrite  out  1 each  APB select, enable, direction.
REQ-013 paddr, pwdata  out  8 each  APB address, write data.
REQ-014 pready  in  1  slave completion; prdata  in  8  slave read data.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS; all outputs registered.
REQ-016 cmd_ready = 1 only in IDLE; accept = cmd_valid && cmd_ready.
REQ-017 On accept: cmd_write/addr/wdata latched into pwrite/paddr/pwdata; next state SETUP.
REQ-018 SETUP: psel=1, pen=0, exactly one cycle, then ACCESS.
REQ-019 ACCESS: psel=1, pen=1; held until pready=1 sampled or timeout.
REQ-020 pwrite/paddr/pwdata stable from SETUP through end of ACCESS; retained in IDLE until next accept.
REQ-021 pwdata driven 0 on read transfers.
REQ-022 pready=1 sampled in ACCESS: next cycle psel=0, pen=0, state IDLE, rsp_valid=1, rsp_err=0, rsp_rdata = prdata (read) or 0 (write).
REQ-023 Wait counter: cleared on entry to ACCESS, +1 per ACCESS cycle with pready=0; saturates, no wrap.
REQ-024 Wait count reaching TIMEOUT with pready=0: next cycle psel=0, pen=0, IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-025 pready=1 on the cycle the count reaches TIMEOUT: normal completion wins, rsp_err=0.
REQ-026 pready ignored in IDLE and SETUP.
REQ-027 rsp_valid high exactly one cycle per accepted command; no backpressure on response.
REQ-028 Minimum transfer: accept edge -> SETUP -> ACCESS -> rsp_valid, 3 cycles after accept with zero waits; next accept possible the same cycle rsp_valid is high.

Reset
REQ-029 prst high: immediately state IDLE, psel=0, pen=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter 0, cmd_ready=0.
REQ-030 prst mid-transfer aborts it with no rsp_valid; cmd_ready=1 from the first edge after prst deasserts.

Structure
REQ-031 Package apb_pkg holds the state enum, address/data width constants (8), and the default TIMEOUT.
REQ-032 One sub-module apb_wait_timer (clear, enable, saturating count, expired flag) is natural; the FSM lives in apb_master.

Verification
REQ-033 Write addr 0x12 data 0xA5, pready=1 in first ACCESS -> SETUP 1 cycle, ACCESS 1 cycle, pwdata=0xA5, rsp_valid pulse, rsp_err=0, rsp_rdata=0.
REQ-034 Read addr 0x34, pready low 3 ACCESS cycles then high with prdata=0x5C -> pen high 4 cycles, paddr stable 0x34, rsp_rdata=0x5C.
REQ-035 TIMEOUT=4, read, pready stuck 0 -> after 4 ACCESS cycles psel/pen drop, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-036 Back-to-back: cmd_valid held for write 0x01 then read 0x02 -> second accept on the rsp_valid cycle, no cycle with pen=1 and psel=0.
REQ-037 prst asserted during ACCESS -> psel/pen/rsp_valid 0 immediately, no response; a new command after release completes normally.
REQ-038 pready=1 while IDLE or SETUP -> ignored, no early completion.
